tdm_demux_1to2: RTL and testbench
=================================

# tdm_demux_1to2

Two-channel demultiplexer with per-channel buffering. It is the receive-side counterpart of the team's 2:1 channel mux. It takes a single tagged stream (data plus a channel select bit) and steers each word to output channel 0 or 1. Each channel has its own DEPTH-entry FIFO and a valid/ready handshake, so one stalled consumer does not block the other channel until that channel's FIFO is full.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 4, entries per channel FIFO (power of two, ≥2).
- CW, 16, width of the per-channel accepted-word counters.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_data  in  WIDTH  input word.
- in_sel  in  1  destination channel: 0 → channel 0, 1 → channel 1 (same encoding as the mux select).
- in_valid  in  1  in_data/in_sel valid.
- in_ready  out  1  block can accept the current word.
- out0_data  out  WIDTH  channel 0 head word.
- out0_valid  out  1  channel 0 head valid.
- out0_ready  in  1  channel 0 consumer accepts.
- out1_data  out  WIDTH  channel 1 head word.
- out1_valid  out  1  channel 1 head valid.
- out1_ready  in  1  channel 1 consumer accepts.
- occ0  out  log2(DEPTH)+1  channel 0 FIFO occupancy, 0..DEPTH.
- occ1  out  log2(DEPTH)+1  channel 1 FIFO occupancy, 0..DEPTH.
- cnt0  out  CW  words accepted into channel 0 since reset.
- cnt1  out  CW  words accepted into channel 1 since reset.

## Operation
- Each channel is a circular FIFO with write and read pointers of log2(DEPTH)+1 bits, using the extra wrap bit.
  - empty = (wr == rd).
  - full = (MSBs differ and LSBs equal).
  - occK = wr − rd, modulo 2^(log2(DEPTH)+1).
- in_ready = in_sel ? ~full1 : ~full0. This is a combinational path from in_sel.
  - The upstream must hold in_sel stable while in_valid is high, per the valid/ready rule.
- Push: in_valid & in_ready at a rising edge writes in_data into FIFO[in_sel] at wr, increments wr, and increments cntK.
- Pop: outK_valid & outK_ready at a rising edge increments rdK.
- outK_valid = ~emptyK. outK_data = mem_K[rdK]. outK_data is stable while outK_valid is high and not popped.
- Push and pop on the same channel in the same cycle are both performed; occupancy is unchanged.
- No bypass when full: a pop in the same cycle does not make in_ready high. in_ready depends only on the registered full flag.
- No drop path. A word is held upstream (in_ready=0) until its channel has space.
- The channels are independent. Channel 1 traffic proceeds while channel 0 is full and stalled.
- Counters wrap from 2^CW−1 to 0 and are never saturated. They increment on accept, not on pop.
- Pointers wrap modulo 2·DEPTH with no special handling.

## Timing
- Reset (rst_n low, asynchronous) forces, immediately and independently of clk:
  - all pointers, occ0/occ1 and cnt0/cnt1 to 0;
  - FIFO storage to 0, so out0_data/out1_data read 0;
  - out0_valid/out1_valid to 0;
  - in_ready to 1 (both FIFOs not full).
- Reset asserted mid-operation discards all buffered words. No output handshake completes in a cycle in which rst_n is low.
- Deassertion is sampled synchronously; the first push can occur at the first rising edge with rst_n high.
- Latency: a word accepted at edge N gives outK_valid=1 with that word from just after edge N. It can be popped at edge N+1 at the earliest: 1 cycle, no bypass.
- Throughput: one push per cycle, plus one pop per channel per cycle.
- in_ready falls the cycle after the DEPTH-th unpopped push to that channel. It rises the cycle after the first pop from a full FIFO.

## Test plan
- Reset then alternating push: after reset, push 0x11 sel=0, 0x22 sel=1, 0x33 sel=0 on consecutive cycles with both readys high → out0 delivers 0x11 then 0x33, out1 delivers 0x22; each word is visible 1 cycle after accept; cnt0=2, cnt1=1.
- Fill channel 0: out0_ready=0, push 4 words (DEPTH=4) sel=0 → occ0=4, in_ready=0 when in_sel=0; with in_sel=1, in_ready=1 and a channel 1 word 0xAA reaches out1 unaffected.
- Full plus simultaneous pop: channel 0 full, raise out0_ready with a sel=0 word pending → in_ready stays 0 that cycle; the word is accepted next cycle; FIFO order is preserved.
- Same-cycle push and pop on channel 1 with occ1=2 for 10 cycles → occ1 stays 2; the output sequence matches input order across pointer wrap.
- Async reset mid-stream: drop rst_n between clock edges with occ0=3 → out0_valid=0, occ0=0, cnt0=0 immediately; after release a new word 0x5C is the first word out of channel 0.
- Counter wrap with CW=4: accept 17 words on channel 0 → cnt0=1.

Source files
------------

// File: rtl/tdm_demux_1to2.sv
// Two-channel demultiplexer: a tagged input stream is steered by in_sel into
// one of two independent DEPTH-entry FIFOs, each drained by its own valid/ready port.
module tdm_demux_1to2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out0_data,
  output logic                       out0_valid,
  input  logic                       out0_ready,
  output logic [WIDTH-1:0]           out1_data,
  output logic                       out1_valid,
  input  logic                       out1_ready,
  output logic [$clog2(DEPTH):0]     occ0,
  output logic [$clog2(DEPTH):0]     occ1,
  output logic [CW-1:0]              cnt0,
  output logic [CW-1:0]              cnt1
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_r  [2];
  logic [PW-1:0]    rd_r  [2];
  logic [WIDTH-1:0] mem_r [2][DEPTH];
  logic [CW-1:0]    cnt_r [2];

  logic [1:0] full_s;
  logic [1:0] empty_s;
  logic [1:0] push_s;
  logic [1:0] pop_s;
  logic [1:0] out_ready_s;

  // Wrap bits differ while the index bits match: writer is a full lap ahead.
  function automatic logic ptr_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
    return (wr[PW-1] != rd[PW-1]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  // Per-channel status flags derived only from registered pointers.
  always_comb begin
    full_s  = 2'b00;
    empty_s = 2'b00;
    for (int k = 0; k < 2; k++) begin
      full_s[k]  = ptr_full(wr_r[k], rd_r[k]);
      empty_s[k] = (wr_r[k] == rd_r[k]);
    end
  end

  assign out_ready_s = {out1_ready, out0_ready};
  assign in_ready    = in_sel ? ~full_s[1] : ~full_s[0];
  assign push_s[0]   = in_valid & in_ready & ~in_sel;
  assign push_s[1]   = in_valid & in_ready & in_sel;
  assign pop_s       = ~empty_s & out_ready_s;

  assign out0_valid = ~empty_s[0];
  assign out1_valid = ~empty_s[1];
  assign out0_data  = mem_r[0][rd_r[0][AW-1:0]];
  assign out1_data  = mem_r[1][rd_r[1][AW-1:0]];
  assign occ0       = wr_r[0] - rd_r[0];
  assign occ1       = wr_r[1] - rd_r[1];
  assign cnt0       = cnt_r[0];
  assign cnt1       = cnt_r[1];

  // FIFO storage, pointers and accept counters; reset clears storage so heads read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        wr_r[k]  <= '0;
        rd_r[k]  <= '0;
        cnt_r[k] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_r[k][i] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push_s[k]) begin
          mem_r[k][wr_r[k][AW-1:0]] <= in_data;
          wr_r[k]  <= wr_r[k] + PW'(1);
          cnt_r[k] <= cnt_r[k] + CW'(1);
        end else begin
          wr_r[k]  <= wr_r[k];
          cnt_r[k] <= cnt_r[k];
        end
        if (pop_s[k]) begin
          rd_r[k] <= rd_r[k] + PW'(1);
        end else begin
          rd_r[k] <= rd_r[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1to2.sv
// Scoreboard bench for tdm_demux_1to2: directed test-plan scenarios followed by
// random traffic, checked against queue-based per-channel FIFO models.
module tb_tdm_demux_1to2;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [2:0]       occ0;
  logic [2:0]       occ1;
  logic [CW-1:0]    cnt0;
  logic [CW-1:0]    cnt1;

  tdm_demux_1to2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .occ0(occ0), .occ1(occ1), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [WIDTH-1:0] sb0[$];
  logic [WIDTH-1:0] sb1[$];
  int occ_m[2];
  int cnt_m[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    sb0.delete();
    sb1.delete();
    for (int k = 0; k < 2; k++) begin
      occ_m[k] = 0;
      cnt_m[k] = 0;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("rst_out0_data", {24'd0, out0_data}, 32'd0);
    chk("rst_out1_data", {24'd0, out1_data}, 32'd0);
    chk("rst_occ0", {29'd0, occ0}, 32'd0);
    chk("rst_occ1", {29'd0, occ1}, 32'd0);
    chk("rst_cnt0", {28'd0, cnt0}, 32'd0);
    chk("rst_cnt1", {28'd0, cnt1}, 32'd0);
  endtask

  // One clock of stimulus: drive at negedge, check flags, apply model at the edge.
  task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    bit acc;
    bit p0;
    bit p1;
    int sk;
    @(negedge clk);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    sk = s ? 1 : 0;
    #1;
    chk("in_ready", {31'd0, in_ready}, (occ_m[sk] < DEPTH) ? 32'd1 : 32'd0);
    chk("occ0", {29'd0, occ0}, occ_m[0]);
    chk("occ1", {29'd0, occ1}, occ_m[1]);
    chk("cnt0", {28'd0, cnt0}, cnt_m[0]);
    chk("cnt1", {28'd0, cnt1}, cnt_m[1]);
    acc = v && (occ_m[sk] < DEPTH);
    p0  = r0 && (occ_m[0] > 0);
    p1  = r1 && (occ_m[1] > 0);
    @(posedge clk);
    #1;
    if (acc) begin
      if (s) sb1.push_back(d);
      else   sb0.push_back(d);
      occ_m[sk]++;
      cnt_m[sk] = (cnt_m[sk] + 1) % (1 << CW);
    end
    if (p0) occ_m[0]--;
    if (p1) occ_m[1]--;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 2; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  // Output monitor: head word must match the oldest expected word; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        chk("out0_valid", {31'd0, out0_valid}, (sb0.size() > 0) ? 32'd1 : 32'd0);
        chk("out1_valid", {31'd0, out1_valid}, (sb1.size() > 0) ? 32'd1 : 32'd0);
        if (sb0.size() > 0) begin
          chk("out0_data", {24'd0, out0_data}, {24'd0, sb0[0]});
          if (out0_ready) void'(sb0.pop_front());
        end
        if (sb1.size() > 0) begin
          chk("out1_data", {24'd0, out1_data}, {24'd0, sb1[0]});
          if (out1_ready) void'(sb1.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    in_data    = 8'h00;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    clear_model();
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Alternating push with both consumers ready.
    cycle(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
    drain();
    chk("alt_cnt0", {28'd0, cnt0}, 32'd2);
    chk("alt_cnt1", {28'd0, cnt1}, 32'd1);

    // Fill channel 0 while channel 1 keeps flowing.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0, 1'b1);
    chk("fill_occ0", {29'd0, occ0}, 32'd4);
    cycle(1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
    // Pop from full: no bypass, the pending word goes in on the following cycle.
    cycle(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
    drain();

    // Steady push/pop on channel 1 at occupancy 2 across pointer wrap.
    cycle(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1);
    chk("steady_occ1", {29'd0, occ1}, 32'd2);
    drain();

    // Asynchronous reset mid-stream with three words held in channel 0.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h70 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_sel   = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 8'h5C, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Counter wrap: 17 accepts on channel 0 with a 4-bit counter.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("wrap_cnt0", {28'd0, cnt0}, 32'd1);
    drain();

    // Random traffic with independent backpressure on each channel.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(3) != 0), 1'($urandom_range(1)), 8'($urandom),
            ($urandom_range(9) < 6), ($urandom_range(9) < 4));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
